// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, ALUOp/FSM encodings and control bundle layout
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 2;
  localparam int CTRL_W   = 9;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FILL  = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;

  // MSB first: reg_dst .. reg_write
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_main_decoder.sv
// rtl/mips_main_decoder.sv - combinational opcode to control bundle decode
module mips_main_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W
) (
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output ctrl_t                   o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_BUBBLE;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      default: o_ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - pipelined MIPS control: FSM, stage registers, load-use stall, branch flush
// Optional illegal-opcode trap enabled by MIPS_PIPE_CTRL_ILLEGAL_TRAP_EN.
module mips_pipe_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int REG_AWIDTH   = 5,
  parameter int FILL_CYCLES  = 4
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_start,
  input  logic                    c_i_stop,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic [REG_AWIDTH-1:0]   c_i_rs,
  input  logic [REG_AWIDTH-1:0]   c_i_rt,
  input  logic                    c_i_zero,
  output logic                    c_o_ce,
  output logic                    c_o_stall,
  output logic                    c_o_pcsrc,
  output logic                    c_o_RegDst,
  output logic                    c_o_ALUSrc,
  output logic [1:0]              c_o_ALUOp,
  output logic                    c_o_Branch,
  output logic                    c_o_MemRead,
  output logic                    c_o_MemWrite,
  output logic                    c_o_RegWrite,
  output logic                    c_o_MemtoReg,
  output logic                    c_o_wb_valid,
`ifdef MIPS_PIPE_CTRL_ILLEGAL_TRAP_EN
  output logic                    c_o_illegal,
`endif
  output logic [1:0]              c_o_state
);

  localparam int CNT_MAX = (FILL_CYCLES > 3) ? FILL_CYCLES : 3;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  ctrl_t                 r_idex, r_exmem, r_memwb;
  logic [REG_AWIDTH-1:0] r_idex_rt;

  ctrl_t w_dec;
  logic  w_ce, w_flush, w_hazard, w_stall, w_bubble_id, w_trap, w_start_ok;

  mips_main_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_dec (
    .i_opcode (c_i_opcode),
    .o_ctrl   (w_dec)
  );

  assign w_ce        = (r_state != ST_IDLE);
  assign w_flush     = w_ce && r_exmem.branch && c_i_zero;
  assign w_hazard    = r_idex.mem_read && (r_idex_rt != '0) &&
                       ((r_idex_rt == c_i_rs) || (r_idex_rt == c_i_rt));
  assign w_stall     = w_ce && w_hazard && !w_flush;
  assign w_bubble_id = (r_state == ST_DRAIN) || w_stall || w_flush;

`ifdef MIPS_PIPE_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  // Every legal opcode sets at least one control bit, so an all-zero decode marks an undecoded one.
  assign w_trap      = w_ce && !w_bubble_id && (w_dec == CTRL_BUBBLE);
  assign w_start_ok  = c_i_start && !r_illegal;
  assign c_o_illegal = r_illegal;

  always_ff @(posedge c_clk) begin
    if (c_rst)       r_illegal <= 1'b0;
    else if (w_trap) r_illegal <= 1'b1;
  end
`else
  assign w_trap     = 1'b0;
  assign w_start_ok = c_i_start;
`endif

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_trap) begin
      r_state <= ST_DRAIN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start_ok) begin
          r_state <= ST_FILL;
          r_cnt   <= '0;
        end
        ST_FILL: if (r_cnt == FILL_LAST) begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        ST_RUN: if (c_i_stop) begin
          r_state <= ST_DRAIN;
          r_cnt   <= '0;
        end
        default: if (r_cnt == DRAIN_LAST) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      r_idex    <= CTRL_BUBBLE;
      r_idex_rt <= '0;
      r_exmem   <= CTRL_BUBBLE;
      r_memwb   <= CTRL_BUBBLE;
    end else if (w_ce) begin
      if (w_bubble_id) begin
        r_idex    <= CTRL_BUBBLE;
        r_idex_rt <= '0;
      end else begin
        r_idex    <= w_dec;
        r_idex_rt <= c_i_rt;
      end
      r_exmem <= w_flush ? CTRL_BUBBLE : r_idex;
      r_memwb <= r_exmem;
    end
  end

  assign c_o_ce       = w_ce;
  assign c_o_stall    = w_stall;
  assign c_o_pcsrc    = w_flush;
  assign c_o_RegDst   = r_idex.reg_dst;
  assign c_o_ALUSrc   = r_idex.alu_src;
  assign c_o_ALUOp    = r_idex.alu_op;
  assign c_o_Branch   = r_exmem.branch;
  assign c_o_MemRead  = r_exmem.mem_read;
  assign c_o_MemWrite = r_exmem.mem_write;
  assign c_o_RegWrite = r_memwb.reg_write;
  assign c_o_MemtoReg = r_memwb.mem_to_reg;
  assign c_o_wb_valid = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign c_o_state    = r_state;

endmodule
